regfile_write_arbiter: RTL
==========================

# regfile_write_arbiter

Shares the single register-file write port between the in-order pipeline writeback stage and a multi-cycle result source (multiply/divide unit, MDU). Writeback always has priority and never stalls. MDU results wait in a small FIFO and drain into idle writeback slots. The block exports a pending-write mask and a stall request so the hazard unit can hold dependent reads and guarantee the FIFO drains.

## Interface
- DATA_WIDTH, 32, register data width
- ADDR_WIDTH, 5, register address width (32 registers)
- DEPTH, 2, MDU FIFO entries (power of two, ≥2)
- STARVE_LIMIT, 4, consecutive blocked cycles before stall request
- clk  input  1  single clock; all state updates on posedge
- reset  input  1  asynchronous, active-low; clears all state immediately
- wb_valid  input  1  pipeline writeback request this cycle
- wb_addr  input  ADDR_WIDTH  pipeline destination register
- wb_data  input  DATA_WIDTH  pipeline result
- mdu_valid  input  1  MDU result offered
- mdu_ready  output  1  FIFO can accept; transfer when mdu_valid & mdu_ready at posedge
- mdu_addr  input  ADDR_WIDTH  MDU destination register
- mdu_data  input  DATA_WIDTH  MDU result
- rf_reg_write  output  1  register-file write enable (registered)
- rf_write_reg_address  output  ADDR_WIDTH  registered write address
- rf_write_data  output  DATA_WIDTH  registered write data
- pending_mask  output  32  bit i set while a write to register i sits in the FIFO or in the output stage as an MDU write
- stall_req  output  1  asks hazard unit to bubble writeback
- fifo_count  output  $clog2(DEPTH)+1  current FIFO occupancy

## Operation
- Write requests with address 0 are no-ops:
  - wb_valid with wb_addr==0 counts as idle writeback.
  - An MDU transfer with mdu_addr==0 completes the handshake but is discarded, not enqueued.
- Arbitration is evaluated at each posedge on the current inputs and state:
  - Effective wb request (wb_valid & wb_addr≠0): output stage loads {1, wb_addr, wb_data}, tagged as non-MDU.
  - Otherwise, FIFO non-empty: output stage loads the FIFO head, tagged MDU, and the head is dequeued.
  - Otherwise: rf_reg_write loads 0; address and data hold their previous values.
- mdu_ready = (fifo_count < DEPTH). There is no enqueue-while-full, even with a simultaneous dequeue.
- Enqueue and dequeue in the same edge are both performed; count is unchanged.
- Pointers wrap modulo DEPTH.
- There is no bypass: an entry enqueued at an edge is dequeued at a later edge at the earliest.
- wait_cnt:
  - Increments, saturating at STARVE_LIMIT, at each edge where the FIFO was non-empty and no dequeue occurred.
  - Clears on any dequeue or when the FIFO is empty.
- stall_req = (fifo_count==DEPTH) | (wait_cnt==STARVE_LIMIT), combinational from state.
- pending_mask is the OR of the one-hot decoded addresses of valid FIFO entries plus the output stage when it holds an MDU-tagged write. It is combinational from state.
- Same-address conflicts are resolved in grant order. A later MDU grant to register R overwrites an earlier wb write to R. The hazard unit prevents this using pending_mask; the arbiter does not reorder.

## Timing
- Reset (asynchronous assert, active-low) sets:
  - rf_reg_write=0, rf_write_reg_address=0, rf_write_data=0
  - fifo_count=0, wait_cnt=0, pending_mask=0, stall_req=0, mdu_ready=1
- Reset mid-operation discards all FIFO entries and any in-flight output write.
- Writeback latency: request sampled at edge E; rf_* outputs valid during cycle E..E+1. The register file commits on the negedge inside that cycle.
- MDU latency: transfer at edge E0 is granted at edge E1 at the earliest, giving outputs during E1..E2. Each cycle with an effective wb request delays the grant by one cycle.
- pending_mask sets the cycle after enqueue and clears the cycle after the output stage moves off that write.

## Test plan
- **Reset:** hold reset=0 with inputs toggling. Required: all outputs at reset values; mdu_ready=1. Release reset, then wb_valid=1, addr=5, data=0xA5A5A5A5. Required: next cycle rf_reg_write=1, address 5, data 0xA5A5A5A5.
- **Drain:** MDU sends addr=7, data=0x1234 while wb is idle. Required:
  - Cycle +1: fifo_count=1, pending_mask=0x80.
  - Cycle +2: rf write of 7/0x1234 with pending_mask still 0x80.
  - Cycle +3: pending_mask=0.
- **Priority/starvation:** wb is busy every cycle (addresses 1..) and MDU sends addr=3. Required: FIFO entry holds, and stall_req rises after 4 blocked edges. Drop wb_valid for one cycle. Required: MDU write issues, then stall_req=0.
- **Full:** with wb busy, MDU pushes 3 results. Required: first two accepted, mdu_ready=0 with fifo_count=2, stall_req=1. Third is accepted only after a dequeue frees space.
- **x0 handling:** wb_valid with addr=0 alongside a non-empty FIFO. Required: the FIFO head is granted. MDU addr=0. Required: handshake completes, fifo_count unchanged, no rf write.
- **Wrap:** 10 MDU results interleaved with idle wb cycles. Required: written in order with correct data across pointer wrap; final fifo_count=0.

Source files
------------

// File: rtl/regfile_write_arbiter_if.sv
// Bundle of writeback, MDU handshake and register-file write signals shared
// between the writeback arbiter (slave) and its environment (master).
interface regfile_write_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 2
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                  wb_valid;
  logic [ADDR_WIDTH-1:0] wb_addr;
  logic [DATA_WIDTH-1:0] wb_data;
  logic                  mdu_valid;
  logic                  mdu_ready;
  logic [ADDR_WIDTH-1:0] mdu_addr;
  logic [DATA_WIDTH-1:0] mdu_data;
  logic                  rf_reg_write;
  logic [ADDR_WIDTH-1:0] rf_write_reg_address;
  logic [DATA_WIDTH-1:0] rf_write_data;
  logic [31:0]           pending_mask;
  logic                  stall_req;
  logic [CNT_W-1:0]      fifo_count;

  modport master (
    output wb_valid, wb_addr, wb_data, mdu_valid, mdu_addr, mdu_data,
    input  mdu_ready, rf_reg_write, rf_write_reg_address, rf_write_data,
           pending_mask, stall_req, fifo_count
  );

  modport slave (
    input  wb_valid, wb_addr, wb_data, mdu_valid, mdu_addr, mdu_data,
    output mdu_ready, rf_reg_write, rf_write_reg_address, rf_write_data,
           pending_mask, stall_req, fifo_count
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between pipeline writeback (priority)
// and a small FIFO of MDU results that drains into idle writeback slots.
module regfile_write_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  regfile_write_arbiter_if.slave bus
);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);

  logic [ADDR_WIDTH-1:0] fifo_addr_mem [DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data_mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [CNT_W-1:0]      count_reg;
  logic [WAIT_W-1:0]     wait_cnt_reg;
  logic                  out_valid_reg;
  logic                  out_mdu_reg;
  logic [ADDR_WIDTH-1:0] out_addr_reg;
  logic [DATA_WIDTH-1:0] out_data_reg;
  logic [DEPTH-1:0]      entry_valid;
  logic [31:0]           pending_next;

  logic wb_eff;
  logic fifo_empty;
  logic fifo_full;
  logic do_deq;
  logic do_enq;

  assign wb_eff     = bus.wb_valid && (bus.wb_addr != '0);
  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == CNT_W'(DEPTH));
  assign do_deq     = !wb_eff && !fifo_empty;
  // Address-0 MDU results still handshake but never occupy a slot.
  assign do_enq     = bus.mdu_valid && !fifo_full && (bus.mdu_addr != '0);

  assign bus.mdu_ready            = !fifo_full;
  assign bus.fifo_count           = count_reg;
  assign bus.stall_req            = fifo_full || (wait_cnt_reg == WAIT_W'(STARVE_LIMIT));
  assign bus.rf_reg_write         = out_valid_reg;
  assign bus.rf_write_reg_address = out_addr_reg;
  assign bus.rf_write_data        = out_data_reg;
  assign bus.pending_mask         = pending_next;

  always_ff @(posedge clk) begin
    if (do_enq) begin
      fifo_addr_mem[wr_ptr_reg] <= bus.mdu_addr;
      fifo_data_mem[wr_ptr_reg] <= bus.mdu_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      wait_cnt_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_mdu_reg   <= 1'b0;
      out_addr_reg  <= '0;
      out_data_reg  <= '0;
    end else begin
      if (do_enq) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_deq) rd_ptr_reg <= rd_ptr_reg + 1'b1;

      case ({do_enq, do_deq})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase

      if (fifo_empty || do_deq)
        wait_cnt_reg <= '0;
      else if (wait_cnt_reg != WAIT_W'(STARVE_LIMIT))
        wait_cnt_reg <= wait_cnt_reg + 1'b1;

      if (wb_eff) begin
        out_valid_reg <= 1'b1;
        out_mdu_reg   <= 1'b0;
        out_addr_reg  <= bus.wb_addr;
        out_data_reg  <= bus.wb_data;
      end else if (do_deq) begin
        out_valid_reg <= 1'b1;
        out_mdu_reg   <= 1'b1;
        out_addr_reg  <= fifo_addr_mem[rd_ptr_reg];
        out_data_reg  <= fifo_data_mem[rd_ptr_reg];
      end else begin
        // Idle slot: address and data hold, only the enable drops.
        out_valid_reg <= 1'b0;
        out_mdu_reg   <= 1'b0;
      end
    end
  end

  // Slot gi is occupied when its distance from the read pointer is below count.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry_valid
      logic [PTR_W-1:0] offset;
      assign offset          = PTR_W'(gi) - rd_ptr_reg;
      assign entry_valid[gi] = ({1'b0, offset} < count_reg);
    end
  endgenerate

  always_comb begin
    pending_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i]) pending_next[fifo_addr_mem[i]] = 1'b1;
    end
    if (out_valid_reg && out_mdu_reg) pending_next[out_addr_reg] = 1'b1;
  end
endmodule
